// File: rtl/ipsxe_floating_point_apm_slice_combine_v1_0.sv
// Sequential combiner for APM P-word slices.
// Accepts NUM_SLICES signed partial results (LS slice first), weights slice k by
// 2^(SHIFT*k), accumulates modulo 2^OUT_WIDTH and holds the result until taken.
module ipsxe_floating_point_apm_slice_combine_v1_0 #(
    parameter int unsigned P_WIDTH    = 48,
    parameter int unsigned SHIFT      = 24,
    parameter int unsigned NUM_SLICES = 3,
    parameter int unsigned OUT_WIDTH  = 96
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_p_valid,
    output logic                 o_p_ready,
    input  logic [P_WIDTH-1:0]   i_p,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic [OUT_WIDTH-1:0] o_res,
    output logic                 o_res_sign,
    output logic                 o_res_zero
);

    localparam int unsigned KW = $clog2(NUM_SLICES);
    localparam logic [KW-1:0] KLast = KW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e               state_q;
    logic [KW-1:0]        k_q;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] acc_d;
    logic [OUT_WIDTH-1:0] p_ext;
    logic [OUT_WIDTH-1:0] addend;
    logic [OUT_WIDTH-1:0] res_q;
    logic                 ready_q;
    logic                 valid_q;
    logic                 sign_q;
    logic                 zero_q;
    logic                 accept;

    assign p_ext  = {{(OUT_WIDTH - P_WIDTH){i_p[P_WIDTH-1]}}, i_p};
    // ready_q is only high in IDLE/ACC, so this never fires in HOLD
    assign accept = i_p_valid && ready_q;

    // Weighted addend via constant-shift mux; k==0 loads instead of adding
    always_comb begin
        addend = '0;
        for (int unsigned j = 0; j < NUM_SLICES; j++) begin
            if (k_q == KW'(j)) begin
                addend = p_ext << (SHIFT * j);
            end
        end
        acc_d = (k_q == '0) ? p_ext : (acc_q + addend);
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (i_flush) begin
                        k_q <= '0;
                    end else if (accept) begin
                        acc_q   <= acc_d;
                        k_q     <= KW'(1);
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    ready_q <= 1'b1;
                    if (i_flush) begin
                        k_q     <= '0;
                        state_q <= StIdle;
                    end else if (accept) begin
                        acc_q <= acc_d;
                        if (k_q == KLast) begin
                            k_q     <= '0;
                            state_q <= StHold;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                            res_q   <= acc_d;
                            sign_q  <= acc_d[OUT_WIDTH-1];
                            zero_q  <= (acc_d == '0);
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                StHold: begin
                    // Flush is ignored here: an issued result is always delivered
                    if (i_res_ready) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    k_q     <= '0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_p_ready   = ready_q;
    assign o_res_valid = valid_q;
    assign o_res       = res_q;
    assign o_res_sign  = sign_q;
    assign o_res_zero  = zero_q;

endmodule
